// File: rtl/ip_sound_write_queue.sv
// Sound-chip write queue: decodes bus writes into a FIFO and replays them
// to the chips at a rate set by the chip master clock enable.
module ip_sound_write_queue #(
   parameter int         NUM_CHIPS       = 1,
   parameter int         FIFO_DEPTH_LOG2 = 3,
   parameter int         ADDR_WAIT       = 12,
   parameter int         DATA_WAIT       = 84,
   parameter logic [7:0] IO_BASE         = 8'h7C,
   parameter int         MEM_DECODE      = 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       mclk_en,
   input  logic                       bus_valid,
   input  logic                       bus_ioreq,
   input  logic                       bus_sltsl,
   input  logic [15:0]                bus_address,
   input  logic [7:0]                 bus_wdata,
   output logic                       out_wr,
   output logic [1:0]                 out_chip,
   output logic                       out_a0,
   output logic [7:0]                 out_data,
   output logic                       busy,
   output logic                       overflow,
   output logic [FIFO_DEPTH_LOG2:0]   fifo_level
);

   localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
   localparam int AW    = FIFO_DEPTH_LOG2;
   localparam int LW    = FIFO_DEPTH_LOG2 + 1;
   localparam int WMAX  = (ADDR_WAIT > DATA_WAIT) ? ADDR_WAIT : DATA_WAIT;
   localparam int CW    = (WMAX < 1) ? 1 : $clog2(WMAX + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT
   } state_t;

   // ---------------- bus decode ----------------
   logic [7:0]  w_io_off;
   logic        w_io_hit;
   logic        w_mem_cyc;
   logic        w_mem_data;
   logic        w_mem_en_wr;
   logic        w_push_req;
   logic [10:0] w_push_ent;
   logic        r_enable;

   assign w_io_off    = bus_address[7:0] - IO_BASE;
   assign w_io_hit    = bus_valid & bus_ioreq &
                        (w_io_off < 8'(2 * NUM_CHIPS));
   assign w_mem_cyc   = (MEM_DECODE != 0) & bus_valid & bus_sltsl;
   assign w_mem_data  = w_mem_cyc & r_enable &
                        (bus_address[15:1] == 15'h3FFA);
   assign w_mem_en_wr = w_mem_cyc & (bus_address == 16'h7FF6);
   assign w_push_req  = w_io_hit | w_mem_data;
   assign w_push_ent  = w_io_hit ?
                        {w_io_off[2:1], w_io_off[0], bus_wdata} :
                        {2'b00, bus_address[0], bus_wdata};

   // Decoded write is staged one clk before it reaches the FIFO
   logic        r_stg_vld;
   logic [10:0] r_stg_ent;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_stg_vld <= 1'b0;
         r_stg_ent <= '0;
         r_enable  <= 1'b0;
      end else begin
         r_stg_vld <= w_push_req;
         r_stg_ent <= w_push_ent;
         if (w_mem_en_wr)
            r_enable <= bus_wdata[0];
      end
   end

   // ---------------- FIFO ----------------
   logic [10:0]   r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [LW-1:0] r_count;
   logic          r_ovf;
   logic          w_full;
   logic          w_empty;
   logic          w_push;
   logic          w_pop;
   logic [10:0]   w_head;

   assign w_full  = (r_count == LW'(DEPTH));
   assign w_empty = (r_count == '0);
   assign w_push  = r_stg_vld & ~w_full;
   assign w_head  = r_mem[r_rptr];

   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wptr] <= r_stg_ent;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_ovf   <= 1'b0;
      end else begin
         if (w_push)
            r_wptr <= r_wptr + 1'b1;
         if (w_pop)
            r_rptr <= r_rptr + 1'b1;
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (r_stg_vld & w_full)
            r_ovf <= 1'b1;
      end
   end

   // ---------------- scheduler ----------------
   state_t        r_state;
   state_t        w_state_nxt;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nxt;
   logic [CW-1:0] w_wait;
   logic [1:0]    r_out_chip;
   logic          r_out_a0;
   logic [7:0]    r_out_data;

   assign w_wait = r_out_a0 ? CW'(DATA_WAIT) : CW'(ADDR_WAIT);

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_pop       = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (mclk_en && !w_empty) begin
               w_pop       = 1'b1;
               w_state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: begin
            w_cnt_nxt   = w_wait;
            w_state_nxt = (w_wait == '0) ? S_IDLE : S_WAIT;
         end
         S_WAIT: begin
            if (mclk_en) begin
               w_cnt_nxt = r_cnt - 1'b1;
               if (r_cnt == CW'(1))
                  w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_out_chip <= '0;
         r_out_a0   <= 1'b0;
         r_out_data <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_pop) begin
            r_out_chip <= w_head[10:9];
            r_out_a0   <= w_head[8];
            r_out_data <= w_head[7:0];
         end
      end
   end

   assign out_wr     = (r_state == S_ISSUE);
   assign out_chip   = r_out_chip;
   assign out_a0     = r_out_a0;
   assign out_data   = r_out_data;
   assign busy       = ~w_empty | (r_state != S_IDLE);
   assign overflow   = r_ovf;
   assign fifo_level = r_count;

endmodule
